// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and the blocks that sit around it.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

  // Next occupancy of a small buffer given this cycle's push/pop.
  function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                          input logic       push,
                                          input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry circular skid buffer: 1-bit write/read indices, occupancy 0..2.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int W = FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_idx_q, wr_idx_d;
  logic         rd_idx_q, rd_idx_d;
  logic [1:0]   occ_q, occ_d;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    occ_d    = occ_q;
    if (clr) begin
      wr_idx_d = 1'b0;
      rd_idx_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_idx_q] = push_data;
        wr_idx_d        = ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_d = ~rd_idx_q;
      end
      occ_d = occ_next(occ_q, push, pop);
    end
  end

  // NOTE: the storage is reset as well, so m_data reads zero out of reset; it is only two words.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
    end
  end

  assign occ     = occ_q;
  assign rd_data = mem_q[rd_idx_q];

  occ_le_2: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);
  no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clr && occ_q == 2'd2));
  no_underrun: assert property (@(posedge clk) disable iff (!rst_n) !(pop && occ_q == 2'd0));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read side of the synchronous FIFO: issues rd_en, catches the registered data_out
// one cycle later and re-presents it as a valid/ready stream through skid_buf2.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow
);

  logic [1:0]           occ;
  logic                 pop;
  logic                 push;
  logic [2:0]           owed_next;
  logic                 infl_q, infl_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                 err_q, err_d;

  assign m_valid = (occ != 2'd0);

  // owed_next counts words already committed to the buffer after this edge; a new read
  // lands one cycle later, so it may only issue while that count leaves a free slot.
  // rd_en is gated by rst_n so the FIFO is never read while this block is held in reset.
  always_comb begin
    pop        = m_valid && m_ready;
    owed_next  = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    rd_en      = rst_n && !empty && !flush && (owed_next < 3'd2);
    push       = infl_q && !flush;
    infl_d     = rd_en;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    err_d      = err_q || (underflow && infl_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q     <= 1'b0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      infl_q     <= infl_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  skid_buf2 #(
    .W(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_data(data_out),
    .pop      (pop),
    .occ      (occ),
    .rd_data  (m_data)
  );

  assign rd_count      = rd_count_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based FIFO model plus a scoreboard of words read
// but not yet delivered; directed scenarios followed by a randomized traffic phase.
module tb_fifo_rd_streamer;
  import fifo_pkg::*;

  localparam int W  = FIFO_WIDTH;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic          underflow = 1'b0;
  logic [W-1:0]  data_out = '0;
  logic          rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] rd_count;
  logic          err_underflow;
  logic          force_uf = 1'b0;

  int checks = 0;
  int failures = 0;

  fifo_word_t    fifo_q[$];
  fifo_word_t    wr_q[$];
  fifo_word_t    owed[$];
  bit            rd_req = 1'b0;
  bit            rd_go = 1'b0;
  bit            rd_prev = 1'b0;
  int            delivered = 0;
  logic [CW-1:0] cnt_exp = '0;
  logic          err_exp = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .FIFO_WIDTH(W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .empty        (empty),
    .underflow    (underflow),
    .data_out     (data_out),
    .rd_en        (rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .flush        (flush),
    .rd_count     (rd_count),
    .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered read data and underflow, writes land at the edge.
  always @(posedge clk) begin
    underflow <= (rd_req && fifo_q.size() == 0) || force_uf;
    if (rd_go) data_out <= fifo_q.pop_front();
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    empty <= (fifo_q.size() == 0);
  end

  // Scoreboard: owed holds words read from the FIFO and not yet delivered, oldest first.
  // The newest one is still in flight when it was read at the previous edge.
  always @(negedge clk) begin
    int vis;
    bit pop_e;
    bit rd_exp;
    if (!rst_n) begin
      check("rst_rd_en", rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_err", err_underflow, 0);
      owed.delete();
      rd_prev = 1'b0;
      rd_req  = 1'b0;
      rd_go   = 1'b0;
      cnt_exp = '0;
      err_exp = 1'b0;
    end else begin
      vis    = owed.size() - int'(rd_prev);
      pop_e  = (vis > 0) && m_ready;
      rd_exp = !empty && !flush && (owed.size() - int'(pop_e) < 2);
      check("m_valid", m_valid, vis > 0);
      if (vis > 0) check("m_data", m_data, owed[0]);
      check("rd_en", rd_en, rd_exp);
      check("rd_count", rd_count, cnt_exp);
      check("err_underflow", err_underflow, err_exp);
      if (underflow && rd_prev) err_exp = 1'b1;
      if (pop_e) begin
        void'(owed.pop_front());
        cnt_exp++;
        delivered++;
      end
      if (flush) owed.delete();
      rd_req = rd_en;
      rd_go  = rd_en && !empty;
      if (rd_go) owed.push_back(fifo_q[0]);
      rd_prev = rd_go;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    bit done = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (owed.size() == 0 && fifo_q.size() == 0 && wr_q.size() == 0 && !rd_prev) done = 1'b1;
      else tick();
    end
    check(tag, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            base;
    int            run;
    int            max_run;
    int            reads;
    bit            found;
    logic [CW-1:0] c0;

    // 1: reset while the FIFO holds three words, then they stream out in order.
    tick(1);
    for (int i = 0; i < 3; i++) wr_q.push_back(fifo_word_t'(16'hA001 + i));
    tick(4);
    rst_n = 1'b1;
    base = delivered;
    drain("t1_drain", 50);
    check("t1_words", delivered - base, 3);

    // 2: eight preloaded words at full throughput.
    c0 = cnt_exp;
    for (int i = 1; i <= 8; i++) wr_q.push_back(fifo_word_t'(i));
    run = 0;
    max_run = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("t2_valid_run", max_run, 8);
    check("t2_rd_count", rd_count, CW'(c0 + 8));
    check("t2_empty", empty, 1);
    tick(1);

    // 3: backpressure for five cycles.
    m_ready = 1'b0;
    base = delivered;
    for (int i = 0; i < 10; i++) wr_q.push_back(fifo_word_t'(16'h3000 + i));
    tick(1);
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_en) reads++;
      if (m_valid) check("t3_hold", m_data, 16'h3000);
    end
    check("t3_reads", reads, 2);
    tick(1);
    drain("t3_drain", 60);
    check("t3_words", delivered - base, 10);

    // 4: flush with one word buffered and one in flight; both are dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_q.push_back(fifo_word_t'(16'h4000 + i));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (owed.size() == 2 && rd_prev) found = 1'b1;
    end
    check("t4_reach_state", found, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    check("t4_valid_after_flush", m_valid, 0);
    tick(1);
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1'b1;
    end
    check("t4_next_seen", found, 1);
    check("t4_next_word", m_data, 16'h4002);
    tick(1);
    drain("t4_drain", 60);

    // 5: single word written into an empty FIFO.
    wr_q.push_back(fifo_word_t'(16'h5A5A));
    tick(1);
    @(negedge clk);
    check("t5_rd_c1", rd_en, 1);
    check("t5_valid_c1", m_valid, 0);
    @(negedge clk);
    check("t5_rd_c2", rd_en, 0);
    check("t5_valid_c2", m_valid, 0);
    @(negedge clk);
    check("t5_valid_c3", m_valid, 1);
    check("t5_data_c3", m_data, 16'h5A5A);
    @(negedge clk);
    check("t5_valid_c4", m_valid, 0);
    tick(1);

    // 6: underflow pulses without a read are ignored; after a read they stick.
    force_uf = 1'b1;
    tick(3);
    force_uf = 1'b0;
    tick(2);
    check("t6_idle_no_err", err_underflow, 0);
    for (int i = 0; i < 4; i++) wr_q.push_back(fifo_word_t'(16'h6000 + i));
    tick(2);
    force_uf = 1'b1;
    tick(1);
    force_uf = 1'b0;
    drain("t6_drain", 40);
    check("t6_err_set", err_underflow, 1);

    // Randomized traffic with backpressure and occasional flushes; rd_count wraps.
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() + wr_q.size() < 12)
        wr_q.push_back(fifo_word_t'($urandom));
      flush = ($urandom_range(0, 30) == 0);
      tick(1);
    end
    flush = 1'b0;
    drain("rand_drain", 100);
    check("rand_err_sticky", err_underflow, 1);
    check("rand_wrapped", delivered > (1 << CW), 1);

    // Reset in the middle of traffic.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_q.push_back(fifo_word_t'(16'h7000 + i));
    tick(3);
    rst_n = 1'b0;
    tick(3);
    check("mid_rst_err", err_underflow, 0);
    rst_n = 1'b1;
    drain("mid_rst_drain", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
